remote_comm: RTL and testbench
==============================

# remote_comm

Host-side Bluetooth command link model. It accepts a 16-bit command from the bench and serialises it onto a UART TX line as two bytes, high byte first. It also receives single-byte responses on RX, such as the 0xA5 acknowledge from the maze runner. It sits between the verification bench and the robot's UART command receiver.

## Interface
Parameters:
- BAUD_DIV, 2604: clocks per UART bit (50 MHz / 19200 baud); legal range 16..4095.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1; name kept as in the codebase).
- cmd  input  16  command word to transmit.
- send_cmd  input  1  one-cycle request to transmit cmd.
- TX  output  1  UART serial out, idle high.
- RX  input  1  UART serial in, idle high.
- cmd_sent  output  1  both command bytes have been fully transmitted.
- resp_rdy  output  1  a valid response byte is held on resp.
- resp  output  8  last received response byte.

## Operation
- UART frame format: 8N1.
  - Start bit 0, then data bits LSB first, then stop bit 1.
  - Each bit lasts exactly BAUD_DIV clocks.
- Transmit FSM states: IDLE, TX_HIGH, TX_LOW.
  - IDLE: when send_cmd=1, latch cmd into a 16-bit holding register, clear cmd_sent, start a frame of cmd[15:8], go to TX_HIGH.
  - TX_HIGH: when the high-byte stop bit completes, start a frame of cmd[7:0] on the next cycle, go to TX_LOW. There is no idle gap between the bytes.
  - TX_LOW: when the low-byte stop bit completes, set cmd_sent and return to IDLE.
- Busy and hold rules:
  - send_cmd while in TX_HIGH or TX_LOW is ignored. The latched command is unchanged.
  - cmd may change after the send_cmd cycle without affecting the transmission.
  - cmd_sent stays high until the next accepted send_cmd.
- Receiver:
  - Idle until RX goes low.
  - Wait BAUD_DIV/2 clocks. If RX is then high, it was a false start: return to idle.
  - Otherwise sample 8 data bits and then the stop bit, each BAUD_DIV clocks apart.
  - Stop bit = 1: load resp with the byte and set resp_rdy.
  - Stop bit = 0 (framing error): discard the byte; resp and resp_rdy are unchanged.
  - resp_rdy clears when the next start bit is detected. resp holds its value until the next valid byte.
- The transmitter and receiver are independent and may run simultaneously.

## Timing
- Reset values: TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00, both FSMs idle.
- Reset asserted mid-frame aborts the transfer immediately and forces the reset values. No partial byte is ever reported.
- TX latency:
  - send_cmd is sampled on the rising edge.
  - The start bit appears on TX in the following cycle.
  - cmd_sent rises 20*BAUD_DIV+1 clocks after the send_cmd edge.
- RX latency: resp_rdy rises 1 clock after the stop-bit mid-sample, i.e. about 9.5*BAUD_DIV (+ sync delay) clocks after the start-bit falling edge.
- Baud counter width is 12 bits; bit counter 4 bits.
- send_cmd in the same cycle cmd_sent is set (the TX_LOW→IDLE cycle) is ignored. A new command needs IDLE.

## Configuration
- Macro: REMOTE_COMM_RX_SYNC_EN.
- Defined: RX passes through a 2-flop synchroniser before start detection, adding 2 clocks to RX latency.
- Undefined: RX is used through a single register stage (1 clock).
- TX behaviour and all reset values are identical in both builds.

## Test plan
- send_cmd with cmd=16'h2000 → TX shows 0x20 frame then 0x00 frame, bit width 2604 clocks; cmd_sent rises 52081 clocks after send_cmd.
- Drive a 0xA5 8N1 frame on RX → resp_rdy rises with resp=8'hA5; the next start bit clears resp_rdy.
- send_cmd(16'h4002), then send_cmd(16'h6000) 1000 clocks later → only 0x40, 0x02 are transmitted; the second request is ignored.
- rst_n=1 during the low-byte frame → TX=1 and cmd_sent=0 next cycle; a new send_cmd(16'h0000) afterwards transmits 0x00, 0x00 normally.
- RX frame 0x5A with stop bit 0 → resp_rdy stays 0 and resp stays 8'h00. A 200-clock low glitch on RX → no byte is reported.

Source files
------------

// File: rtl/remote_comm.sv
// Host-side UART command link: sends a 16-bit command as two 8N1 bytes (high first)
// and receives single-byte responses. Optional macro: REMOTE_COMM_RX_SYNC_EN (2-flop RX synchroniser).
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,      // active-high despite the name
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t   tx_state_reg;
  logic [11:0] tx_baud_reg;
  logic [3:0]  tx_bit_reg;
  logic [15:0] hold_reg;
  logic        tx_reg;
  logic        cmd_sent_reg;
  logic [7:0]  tx_byte;

  assign tx_byte = (tx_state_reg == TX_HIGH) ? hold_reg[15:8] : hold_reg[7:0];

  // tx_bit_reg: 0 = start, 1..8 = data, 9 = stop; 10 is the closing cycle of the low byte
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state_reg <= IDLE;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      hold_reg     <= '0;
      tx_reg       <= 1'b1;
      cmd_sent_reg <= 1'b0;
    end else begin
      case (tx_state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (send_cmd) begin
            hold_reg     <= cmd;
            cmd_sent_reg <= 1'b0;
            tx_reg       <= 1'b0;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_state_reg <= TX_HIGH;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (tx_state_reg == TX_LOW && tx_bit_reg == 4'd10) begin
            cmd_sent_reg <= 1'b1;
            tx_state_reg <= IDLE;
          end else if (tx_baud_reg == BAUD_LAST) begin
            tx_baud_reg <= '0;
            if (tx_bit_reg == 4'd9) begin
              if (tx_state_reg == TX_HIGH) begin
                tx_reg       <= 1'b0;
                tx_bit_reg   <= '0;
                tx_state_reg <= TX_LOW;
              end else begin
                tx_bit_reg <= 4'd10;
              end
            end else begin
              tx_bit_reg <= tx_bit_reg + 4'd1;
              tx_reg     <= (tx_bit_reg == 4'd8) ? 1'b1 : tx_byte[tx_bit_reg[2:0]];
            end
          end else begin
            tx_baud_reg <= tx_baud_reg + 12'd1;
          end
        end
        default: tx_state_reg <= IDLE;
      endcase
    end
  end

  assign TX       = tx_reg;
  assign cmd_sent = cmd_sent_reg;

  // ---------------- receiver input stage ----------------
  logic rx_s;
`ifdef REMOTE_COMM_RX_SYNC_EN
  logic rx_meta_reg;
  logic rx_sync_reg;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rx_sync_reg <= rx_meta_reg;
    end
  end
`else
  logic rx_sync_reg;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rx_sync_reg <= 1'b1;
    else       rx_sync_reg <= RX;
  end
`endif
  assign rx_s = rx_sync_reg;

  // ---------------- receiver ----------------
  rx_state_t   rx_state_reg;
  logic [11:0] rx_baud_reg;
  logic [3:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;
  logic [7:0]  resp_reg;
  logic        resp_rdy_reg;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_baud_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      resp_reg     <= '0;
      resp_rdy_reg <= 1'b0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_s) begin
            resp_rdy_reg <= 1'b0;
            rx_baud_reg  <= '0;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          // re-check the line half a bit in; a high level means the low pulse was a glitch
          if (rx_baud_reg == HALF_LAST) begin
            rx_baud_reg <= '0;
            rx_bit_reg  <= '0;
            rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud_reg <= rx_baud_reg + 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_baud_reg == BAUD_LAST) begin
            rx_baud_reg  <= '0;
            rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
            if (rx_bit_reg == 4'd7) rx_state_reg <= RX_STOP;
            else                    rx_bit_reg   <= rx_bit_reg + 4'd1;
          end else begin
            rx_baud_reg <= rx_baud_reg + 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_baud_reg == BAUD_LAST) begin
            rx_baud_reg  <= '0;
            rx_state_reg <= RX_IDLE;
            if (rx_s) begin
              resp_reg     <= rx_shift_reg;
              resp_rdy_reg <= 1'b1;
            end
          end else begin
            rx_baud_reg <= rx_baud_reg + 12'd1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign resp     = resp_reg;
  assign resp_rdy = resp_rdy_reg;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: TX framing/latency, busy/ignore rules,
// mid-frame reset, and RX valid/framing-error/glitch handling.
module tb_remote_comm;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cmd = '0;
  logic        send_cmd = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  int n_checks = 0;
  int n_fail   = 0;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .send_cmd(send_cmd),
    .TX(TX), .RX(RX), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // returns 1 time unit after the edge that samples send_cmd
  task automatic issue(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    @(posedge clk);
    #1;
    send_cmd = 1'b0;
    cmd = 16'hFFFF;
  endtask

  // entered 1 unit after a frame's first edge, leaves 1 unit after the next frame's first edge
  task automatic capture_frame(input string tag, input logic [7:0] exp, input logic inject);
    logic [9:0] cap;
    cap = '0;
    clks(BD / 2);
    for (int k = 0; k < 10; k++) begin
      cap[k] = TX;
      if (k < 9) begin
        if (inject && k == 3) begin
          send_cmd = 1'b1;
          cmd = 16'h6000;
          clks(1);
          send_cmd = 1'b0;
          clks(BD - 1);
        end else begin
          clks(BD);
        end
      end
    end
    chk(tag, {22'd0, cap}, {22'd0, 1'b1, exp, 1'b0});
    clks(BD / 2);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic peek);
    RX = 1'b0;
    if (peek) begin
      clks(6);
      chk("rx_rdy_clear_on_start", {31'd0, resp_rdy}, 32'd0);
      chk("rx_resp_hold_on_start", {24'd0, resp}, 32'hA5);
      clks(BD - 6);
    end else begin
      clks(BD);
    end
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      clks(BD);
    end
    RX = stop;
    clks(BD);
    RX = 1'b1;
    clks(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clks(3);
    chk("rst_tx", {31'd0, TX}, 32'd1);
    chk("rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
    chk("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("rst_resp", {24'd0, resp}, 32'h00);
    @(negedge clk);
    rst_n = 1'b0;
    clks(2);
    chk("idle_tx", {31'd0, TX}, 32'd1);

    // 0x2000: 0x20 frame then 0x00 frame; cmd_sent exactly 20*BD+1 clocks after the send edge
    issue(16'h2000);
    chk("t1_start_bit", {31'd0, TX}, 32'd0);
    capture_frame("t1_hi_0x20", 8'h20, 1'b0);
    capture_frame("t1_lo_0x00", 8'h00, 1'b0);
    chk("t1_cmd_sent_before", {31'd0, cmd_sent}, 32'd0);
    send_cmd = 1'b1;            // lands on the TX_LOW->IDLE edge: must be ignored
    cmd = 16'h7777;
    clks(1);
    send_cmd = 1'b0;
    chk("t1_cmd_sent_rise", {31'd0, cmd_sent}, 32'd1);
    clks(BD);
    chk("t1_done_cycle_send_ignored_tx", {31'd0, TX}, 32'd1);
    chk("t1_cmd_sent_holds", {31'd0, cmd_sent}, 32'd1);

    // 0x4002 with a second request mid high byte
    issue(16'h4002);
    chk("t2_cmd_sent_cleared", {31'd0, cmd_sent}, 32'd0);
    capture_frame("t2_hi_0x40", 8'h40, 1'b1);
    capture_frame("t2_lo_0x02", 8'h02, 1'b0);
    chk("t2_cmd_sent_before", {31'd0, cmd_sent}, 32'd0);
    clks(1);
    chk("t2_cmd_sent_rise", {31'd0, cmd_sent}, 32'd1);
    clks(2 * BD);
    chk("t2_no_second_frame", {31'd0, TX}, 32'd1);

    // reset during the low byte of 0x1200, then a clean 0x0000
    issue(16'h1200);
    clks(11 * BD + BD / 2);
    chk("t3_low_byte_bit0", {31'd0, TX}, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t3_rst_tx_immediate", {31'd0, TX}, 32'd1);
    clks(1);
    chk("t3_rst_tx", {31'd0, TX}, 32'd1);
    chk("t3_rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    clks(2);
    chk("t3_idle_after_rst", {31'd0, TX}, 32'd1);
    issue(16'h0000);
    capture_frame("t3_hi_0x00", 8'h00, 1'b0);
    capture_frame("t3_lo_0x00", 8'h00, 1'b0);
    chk("t3_cmd_sent_before", {31'd0, cmd_sent}, 32'd0);
    clks(1);
    chk("t3_cmd_sent_rise", {31'd0, cmd_sent}, 32'd1);

    // receiver
    rx_frame(8'h5A, 1'b0, 1'b0);
    chk("rx_ferr_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("rx_ferr_resp", {24'd0, resp}, 32'h00);
    RX = 1'b0;
    clks(3);
    RX = 1'b1;
    clks(2 * BD);
    chk("rx_glitch_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("rx_glitch_resp", {24'd0, resp}, 32'h00);
    rx_frame(8'hA5, 1'b1, 1'b0);
    chk("rx_a5_rdy", {31'd0, resp_rdy}, 32'd1);
    chk("rx_a5_resp", {24'd0, resp}, 32'hA5);
    rx_frame(8'h3C, 1'b1, 1'b1);
    chk("rx_3c_rdy", {31'd0, resp_rdy}, 32'd1);
    chk("rx_3c_resp", {24'd0, resp}, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
